// File: rtl/range_deser_pkg.sv
// Shared definitions for the range deserializer and the downstream range combiner:
// FSM state encoding, counter-width helper and default word geometry.
package range_deser_pkg;

  localparam int RANGE_W_DEFAULT   = 4;
  localparam int RANGE_OFF_DEFAULT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Bits needed to represent values 0..value-1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/range_deser_if.sv
// Serial-in / word-out handshake bundle for range_deser; the deserializer uses
// the slave modport, the stream source and word consumer use master.
interface range_deser_if
  import range_deser_pkg::*;
#(
  parameter int W   = RANGE_W_DEFAULT,
  parameter int OFF = RANGE_OFF_DEFAULT
);

  logic                 in_bit;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         out_be;
  logic [0:W-1]         out_le;
  logic [OFF+W-1:OFF]   out_me;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_err;

  modport slave (
    input  in_bit, in_valid, out_ready,
    output in_ready, out_be, out_le, out_me, out_valid, out_err
  );

  modport master (
    output in_bit, in_valid, out_ready,
    input  in_ready, out_be, out_le, out_me, out_valid, out_err
  );

endinterface

// File: rtl/range_deser_shift.sv
// Serial shift register plus accepted-bit counter for range_deser.
// MSB_FIRST selects whether new bits enter at the LSB (shift left) or the MSB (shift right).
module range_deser_shift #(
  parameter int W         = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_bit,
  input  logic          sr_en,
  input  logic          cnt_en,
  input  logic          cnt_clr,
  output logic [W-1:0]  sr,
  output logic [W-1:0]  sr_next,
  output logic [CW-1:0] count
);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_next = {sr[W-2:0], in_bit};
    end else begin : g_lsb_first
      assign sr_next = {in_bit, sr[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      count <= '0;
    end else begin
      if (sr_en) begin
        sr <= sr_next;
      end
      if (cnt_clr) begin
        count <= '0;
      end else if (cnt_en) begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/range_deser.sv
// Bit-serial to parallel deserializer presenting one word through descending,
// ascending and offset range views. Optional trailing even-parity bit: RANGE_DESER_PARITY_EN.
module range_deser
  import range_deser_pkg::*;
#(
  parameter int W         = RANGE_W_DEFAULT,
  parameter int OFF       = RANGE_OFF_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  range_deser_if.slave  bus
);

`ifdef RANGE_DESER_PARITY_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif
  localparam int              CW       = clog2(NBITS + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(NBITS - 1);

  state_t        state, state_nxt;
  logic          acc;
  logic          done_acc;
  logic          sr_en;
  logic [W-1:0]  sr;
  logic [W-1:0]  sr_next;
  logic [W-1:0]  word_nxt;
  logic [W-1:0]  word_p1;
  logic [CW-1:0] count;

  assign bus.in_ready = (state == HOLD) ? bus.out_ready : 1'b1;
  assign acc          = bus.in_valid && bus.in_ready;
  assign done_acc     = acc && (state == FILL) && (count == LAST_CNT);

`ifdef RANGE_DESER_PARITY_EN
  logic err_nxt;
  logic err_p1;

  // The parity bit is checked but never shifted in, so sr already holds the data word.
  assign sr_en    = acc && !done_acc;
  assign word_nxt = sr;
  assign err_nxt  = (^sr) ^ bus.in_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_p1 <= 1'b0;
    end else if (done_acc) begin
      err_p1 <= err_nxt;
    end else if (state == HOLD && bus.out_ready) begin
      err_p1 <= 1'b0;
    end
  end

  assign bus.out_err = err_p1;
`else
  assign sr_en       = acc;
  assign word_nxt    = sr_next;
  assign bus.out_err = 1'b0;
`endif

  range_deser_shift #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST),
    .CW        (CW)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_bit  (bus.in_bit),
    .sr_en   (sr_en),
    .cnt_en  (acc),
    .cnt_clr (done_acc),
    .sr      (sr),
    .sr_next (sr_next),
    .count   (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A handoff in HOLD may coincide with the first bit of the next word.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc) state_nxt = FILL;
      FILL: if (done_acc) state_nxt = HOLD;
      HOLD: if (bus.out_ready) state_nxt = acc ? FILL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output word stage: loaded on the completing accept, frozen while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_p1 <= '0;
    end else if (done_acc) begin
      word_p1 <= word_nxt;
    end
  end

  assign bus.out_valid = (state == HOLD);
  assign bus.out_be    = word_p1;
  assign bus.out_le    = word_p1;
  assign bus.out_me    = word_p1;

endmodule
